// File: rtl/bp_be_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : bp_be_pkg
//  Purpose : Shared types for the backend register-file writeback arbiter:
//            processor configuration selector, arbiter FSM state, and the
//            {v, addr, data} writeback bus struct used by every source.
//  Ports   : none (package)
//  Rev     : 1.0  initial release
// ============================================================================
package bp_be_pkg;

   typedef enum logic [0:0] {
      e_bp_inv_cfg = 1'b0
   } bp_params_e;

   localparam int bp_reg_addr_width_gp = 5;
   localparam int bp_dword_width_gp    = 64;

   typedef enum logic [0:0] {
      e_clear = 1'b0,
      e_run   = 1'b1
   } bp_be_rf_wb_state_e;

   typedef struct packed {
      logic                            v;
      logic [bp_reg_addr_width_gp-1:0] addr;
      logic [bp_dword_width_gp-1:0]    data;
   } bp_be_rf_wb_s;

   function automatic int bp_reg_addr_width(input bp_params_e cfg);
      case (cfg)
         e_bp_inv_cfg: return bp_reg_addr_width_gp;
         default:      return bp_reg_addr_width_gp;
      endcase
   endfunction

   function automatic int bp_dword_width(input bp_params_e cfg);
      case (cfg)
         e_bp_inv_cfg: return bp_dword_width_gp;
         default:      return bp_dword_width_gp;
      endcase
   endfunction

   // x0 is hardwired to zero: a write to it is consumed but never reaches the
   // register file.
   function automatic bp_be_rf_wb_s wb_suppress_x0(input bp_be_rf_wb_s s);
      bp_be_rf_wb_s r;
      r   = s;
      r.v = s.v & (s.addr != '0);
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/bsg_one_fifo.sv
`default_nettype none
// ============================================================================
//  Module  : bsg_one_fifo
//  Purpose : Single-entry holding buffer. Loads on v_i when empty, empties on
//            yumi_i. Load and drain are mutually exclusive since a load needs
//            the entry to be empty.
//  Ports   : clk_i, reset_i        clock, synchronous active-high reset
//            v_i / data_i          load request and payload
//            v_o / data_o          entry valid and payload
//            yumi_i                consumer takes the entry this cycle
//  Rev     : 1.0  initial release
// ============================================================================
module bsg_one_fifo #(
   parameter int width_p = 69
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               v_i,
   input  logic [width_p-1:0] data_i,
   output logic               v_o,
   output logic [width_p-1:0] data_o,
   input  logic               yumi_i
);

   logic               v_q, v_d;
   logic [width_p-1:0] data_q, data_d;

   always_comb begin
      v_d    = v_q;
      data_d = data_q;
      if (yumi_i) begin
         v_d = 1'b0;
      end else if (v_i && !v_q) begin
         v_d    = 1'b1;
         data_d = data_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         v_q    <= 1'b0;
         data_q <= '0;
      end else begin
         v_q    <= v_d;
         data_q <= data_d;
      end
   end

   assign v_o    = v_q;
   assign data_o = data_q;

endmodule
`default_nettype wire

// File: rtl/bp_be_rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module  : bp_be_rf_wb_arbiter
//  Purpose : Integer register-file rd write-port controller. Optionally clears
//            every register after reset, then arbitrates the single write port
//            between pipeline commit (highest), config writes, and a buffered
//            long-latency result (lowest), raising a stall when that buffered
//            result starves. Clear sequence built only when
//            BP_BE_RF_CLEAR_ON_RESET_EN is defined.
//  Ports   : clk_i, reset_i                     clock, sync active-high reset
//            pipe_w_v_i/addr/data               commit write, no backpressure
//            cfg_w_v_i/addr/data, cfg_ack_o     config write, held until ack
//            long_v_i/addr/data, long_ready_o   long result, valid/ready
//            long_stall_o                       starvation stall request
//            rd_w_v_o/rd_addr_o/rd_data_o       register file write bus
//            init_done_o                        clear finished
//  Rev     : 1.0  initial release
// ============================================================================
module bp_be_rf_wb_arbiter
   import bp_be_pkg::*;
#(
   parameter bp_params_e bp_params_p    = e_bp_inv_cfg,
   parameter int         starve_limit_p = 8,
   localparam int        reg_addr_width_p = bp_reg_addr_width(bp_params_p),
   localparam int        dword_width_p    = bp_dword_width(bp_params_p)
) (
   input  logic                        clk_i,
   input  logic                        reset_i,
   input  logic                        pipe_w_v_i,
   input  logic [reg_addr_width_p-1:0] pipe_addr_i,
   input  logic [dword_width_p-1:0]    pipe_data_i,
   input  logic                        cfg_w_v_i,
   input  logic [reg_addr_width_p-1:0] cfg_addr_i,
   input  logic [dword_width_p-1:0]    cfg_data_i,
   output logic                        cfg_ack_o,
   input  logic                        long_v_i,
   input  logic [reg_addr_width_p-1:0] long_addr_i,
   input  logic [dword_width_p-1:0]    long_data_i,
   output logic                        long_ready_o,
   output logic                        long_stall_o,
   output logic                        rd_w_v_o,
   output logic [reg_addr_width_p-1:0] rd_addr_o,
   output logic [dword_width_p-1:0]    rd_data_o,
   output logic                        init_done_o
);

   localparam int starve_width_lp = $clog2(starve_limit_p + 1);
   localparam int buf_width_lp    = reg_addr_width_p + dword_width_p;
   localparam logic [starve_width_lp-1:0] starve_max_lp = starve_width_lp'(starve_limit_p);

   bp_be_rf_wb_state_e            state_q, state_d;
   logic [starve_width_lp-1:0]    starve_q, starve_d;
`ifdef BP_BE_RF_CLEAR_ON_RESET_EN
   logic [reg_addr_width_p-1:0]   clr_cnt_q, clr_cnt_d;
`endif

   bp_be_rf_wb_s                  pipe_wb, cfg_wb, buf_wb, rd_wb;
   logic                          buf_v, buf_load, buf_yumi;
   logic [buf_width_lp-1:0]       buf_data;

   assign pipe_wb = '{v: pipe_w_v_i, addr: pipe_addr_i, data: pipe_data_i};
   assign cfg_wb  = '{v: cfg_w_v_i,  addr: cfg_addr_i,  data: cfg_data_i};
   assign buf_wb  = '{v: buf_v, addr: buf_data[buf_width_lp-1 -: reg_addr_width_p],
                      data: buf_data[dword_width_p-1:0]};

   // Ready is a function of flops only, so upstream sees no combinational path.
   assign long_ready_o = ~buf_v & (state_q == e_run);
   assign buf_load     = long_v_i & long_ready_o;

   bsg_one_fifo #(
      .width_p (buf_width_lp)
   ) long_buf (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .v_i     (buf_load),
      .data_i  ({long_addr_i, long_data_i}),
      .v_o     (buf_v),
      .data_o  (buf_data),
      .yumi_i  (buf_yumi)
   );

   always_comb begin
      rd_wb     = '0;
      cfg_ack_o = 1'b0;
      buf_yumi  = 1'b0;
      state_d   = state_q;
`ifdef BP_BE_RF_CLEAR_ON_RESET_EN
      clr_cnt_d = clr_cnt_q;
`endif
      // Grants are blocked while reset is asserted so a pending cfg request or
      // buffered result is dropped rather than written in the reset cycle.
      if (!reset_i) begin
         case (state_q)
`ifdef BP_BE_RF_CLEAR_ON_RESET_EN
            e_clear: begin
               rd_wb.v    = 1'b1;
               rd_wb.addr = clr_cnt_q;
               clr_cnt_d  = clr_cnt_q + 1'b1;
               if (&clr_cnt_q) state_d = e_run;
            end
`endif
            e_run: begin
               if (pipe_w_v_i) begin
                  rd_wb = wb_suppress_x0(pipe_wb);
               end else if (cfg_w_v_i) begin
                  cfg_ack_o = 1'b1;
                  rd_wb     = wb_suppress_x0(cfg_wb);
               end else if (buf_v) begin
                  buf_yumi = 1'b1;
                  rd_wb    = wb_suppress_x0(buf_wb);
               end
            end
            default: state_d = e_run;
         endcase
      end

      starve_d = starve_q;
      if (buf_load || buf_yumi) begin
         starve_d = '0;
      end else if (buf_v && (starve_q != starve_max_lp)) begin
         starve_d = starve_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
`ifdef BP_BE_RF_CLEAR_ON_RESET_EN
         state_q   <= e_clear;
         clr_cnt_q <= '0;
`else
         state_q   <= e_run;
`endif
         starve_q  <= '0;
      end else begin
         state_q   <= state_d;
         starve_q  <= starve_d;
`ifdef BP_BE_RF_CLEAR_ON_RESET_EN
         clr_cnt_q <= clr_cnt_d;
`endif
      end
   end

   assign rd_w_v_o     = rd_wb.v;
   assign rd_addr_o    = rd_wb.addr;
   assign rd_data_o    = rd_wb.data;
   assign long_stall_o = (starve_q == starve_max_lp);

`ifdef BP_BE_RF_CLEAR_ON_RESET_EN
   assign init_done_o = (state_q == e_run);
`else
   assign init_done_o = 1'b1;
`endif

`ifndef SYNTHESIS
   // The commit path cannot be stalled, so a commit during clear is lost.
   a_no_pipe_in_clear: assert property (@(posedge clk_i) disable iff (reset_i)
      !((state_q == e_clear) && pipe_w_v_i));
`endif

endmodule
`default_nettype wire

// File: tb/tb_bp_be_rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module  : tb_bp_be_rf_wb_arbiter
//  Purpose : Self-checking bench for bp_be_rf_wb_arbiter. Expected register
//            file writes are queued when stimulus is driven and popped by a
//            monitor whenever the DUT drives rd_w_v_o. Handles both builds of
//            BP_BE_RF_CLEAR_ON_RESET_EN.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_bp_be_rf_wb_arbiter;

   logic        clk_i = 1'b0;
   logic        reset_i = 1'b1;
   logic        pipe_w_v_i = 1'b0;
   logic [4:0]  pipe_addr_i = '0;
   logic [63:0] pipe_data_i = '0;
   logic        cfg_w_v_i = 1'b0;
   logic [4:0]  cfg_addr_i = '0;
   logic [63:0] cfg_data_i = '0;
   logic        cfg_ack_o;
   logic        long_v_i = 1'b0;
   logic [4:0]  long_addr_i = '0;
   logic [63:0] long_data_i = '0;
   logic        long_ready_o;
   logic        long_stall_o;
   logic        rd_w_v_o;
   logic [4:0]  rd_addr_o;
   logic [63:0] rd_data_o;
   logic        init_done_o;

   always #5 clk_i = ~clk_i;

   bp_be_rf_wb_arbiter #(
      .starve_limit_p (8)
   ) dut (
      .clk_i        (clk_i),
      .reset_i      (reset_i),
      .pipe_w_v_i   (pipe_w_v_i),
      .pipe_addr_i  (pipe_addr_i),
      .pipe_data_i  (pipe_data_i),
      .cfg_w_v_i    (cfg_w_v_i),
      .cfg_addr_i   (cfg_addr_i),
      .cfg_data_i   (cfg_data_i),
      .cfg_ack_o    (cfg_ack_o),
      .long_v_i     (long_v_i),
      .long_addr_i  (long_addr_i),
      .long_data_i  (long_data_i),
      .long_ready_o (long_ready_o),
      .long_stall_o (long_stall_o),
      .rd_w_v_o     (rd_w_v_o),
      .rd_addr_o    (rd_addr_o),
      .rd_data_o    (rd_data_o),
      .init_done_o  (init_done_o)
   );

   typedef struct {
      logic [4:0]  addr;
      logic [63:0] data;
   } exp_wr_t;

   exp_wr_t sb_q[$];
   int      n_checks = 0;
   int      n_errors = 0;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, required %0h", tag, act, exp);
      end
   endtask

   task automatic push(input logic [4:0] a, input logic [63:0] d);
      exp_wr_t e;
      e.addr = a;
      e.data = d;
      sb_q.push_back(e);
   endtask

   task automatic next_cycle();
      @(posedge clk_i);
      #1;
   endtask

   // Every observed register-file write must match the oldest expected one.
   always @(negedge clk_i) begin
      if (!reset_i && rd_w_v_o !== 1'b0) begin
         if (sb_q.size() == 0) begin
            check("sb_unexpected_wr", {63'd0, rd_w_v_o}, 64'd0);
         end else begin
            exp_wr_t e;
            e = sb_q.pop_front();
            check("wr_addr", {59'd0, rd_addr_o}, {59'd0, e.addr});
            check("wr_data", rd_data_o, e.data);
         end
      end
   end

`ifdef BP_BE_RF_CLEAR_ON_RESET_EN
   task automatic run_clear();
      for (int i = 0; i < 32; i++) begin
         push(i[4:0], 64'd0);
         @(negedge clk_i);
         check("clr_v", {63'd0, rd_w_v_o}, 64'd1);
         check("clr_ack", {63'd0, cfg_ack_o}, 64'd0);
         check("clr_ready", {63'd0, long_ready_o}, 64'd0);
         check("clr_done", {63'd0, init_done_o}, 64'd0);
         next_cycle();
      end
   endtask
`endif

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, required finish");
      $fatal(1);
   end

   initial begin
      // ---------------- reset and clear ----------------
      repeat (2) @(posedge clk_i);
      #1;
      reset_i = 1'b0;
      check("rst_stall", {63'd0, long_stall_o}, 64'd0);
`ifdef BP_BE_RF_CLEAR_ON_RESET_EN
      cfg_w_v_i  = 1'b1;
      cfg_addr_i = 5'd4;
      cfg_data_i = 64'h44;
      run_clear();
      // Held cfg request is finally acked in the first run cycle.
      push(5'd4, 64'h44);
      @(negedge clk_i);
      check("clr_done_33", {63'd0, init_done_o}, 64'd1);
      check("cfg_ack_after_clr", {63'd0, cfg_ack_o}, 64'd1);
      next_cycle();
      cfg_w_v_i = 1'b0;
`else
      @(negedge clk_i);
      check("rst_done", {63'd0, init_done_o}, 64'd1);
      check("rst_wv", {63'd0, rd_w_v_o}, 64'd0);
      check("rst_ack", {63'd0, cfg_ack_o}, 64'd0);
      check("rst_ready", {63'd0, long_ready_o}, 64'd1);
      next_cycle();
      pipe_w_v_i  = 1'b1;
      pipe_addr_i = 5'd1;
      pipe_data_i = 64'h1;
      push(5'd1, 64'h1);
      @(negedge clk_i);
      check("pipe_x1_v", {63'd0, rd_w_v_o}, 64'd1);
      next_cycle();
      pipe_w_v_i = 1'b0;
`endif
      @(negedge clk_i);
      check("idle_ready", {63'd0, long_ready_o}, 64'd1);
      next_cycle();

      // ---------------- priority ----------------
      pipe_w_v_i = 1'b1; pipe_addr_i = 5'd3; pipe_data_i = 64'hAA;
      cfg_w_v_i  = 1'b1; cfg_addr_i  = 5'd4; cfg_data_i  = 64'hBB;
      long_v_i   = 1'b1; long_addr_i = 5'd5; long_data_i = 64'hCC;
      push(5'd3, 64'hAA);
      push(5'd4, 64'hBB);
      push(5'd5, 64'hCC);
      @(negedge clk_i);
      check("pri0_ack", {63'd0, cfg_ack_o}, 64'd0);
      check("pri0_ready", {63'd0, long_ready_o}, 64'd1);
      next_cycle();
      pipe_w_v_i = 1'b0;
      long_v_i   = 1'b0;
      @(negedge clk_i);
      check("pri1_ack", {63'd0, cfg_ack_o}, 64'd1);
      check("pri1_ready", {63'd0, long_ready_o}, 64'd0);
      next_cycle();
      cfg_w_v_i = 1'b0;
      @(negedge clk_i);
      check("pri2_v", {63'd0, rd_w_v_o}, 64'd1);
      check("pri2_addr", {59'd0, rd_addr_o}, 64'd5);
      next_cycle();
      @(negedge clk_i);
      check("pri3_ready", {63'd0, long_ready_o}, 64'd1);
      check("pri3_v", {63'd0, rd_w_v_o}, 64'd0);
      next_cycle();

      // ---------------- x0 suppression ----------------
      cfg_w_v_i = 1'b1; cfg_addr_i = 5'd0; cfg_data_i = 64'hFF;
      @(negedge clk_i);
      check("x0_cfg_ack", {63'd0, cfg_ack_o}, 64'd1);
      check("x0_cfg_v", {63'd0, rd_w_v_o}, 64'd0);
      next_cycle();
      cfg_w_v_i = 1'b0;
      long_v_i = 1'b1; long_addr_i = 5'd0; long_data_i = 64'hEE;
      @(negedge clk_i);
      check("x0_long_ready", {63'd0, long_ready_o}, 64'd1);
      next_cycle();
      long_v_i = 1'b0;
      @(negedge clk_i);
      check("x0_long_v", {63'd0, rd_w_v_o}, 64'd0);
      next_cycle();
      @(negedge clk_i);
      check("x0_long_consumed", {63'd0, long_ready_o}, 64'd1);
      next_cycle();

      // ---------------- starvation ----------------
      pipe_w_v_i = 1'b1; pipe_addr_i = 5'd6; pipe_data_i = 64'h600;
      long_v_i   = 1'b1; long_addr_i = 5'd7; long_data_i = 64'h77;
      push(5'd6, 64'h600);
      @(negedge clk_i);
      check("stv_ready", {63'd0, long_ready_o}, 64'd1);
      for (int k = 1; k <= 9; k++) begin
         next_cycle();
         long_v_i    = 1'b0;
         pipe_data_i = 64'h600 + 64'(k);
         push(5'd6, 64'h600 + 64'(k));
         @(negedge clk_i);
         check("stv_stall", {63'd0, long_stall_o}, (k == 9) ? 64'd1 : 64'd0);
      end
      next_cycle();
      pipe_w_v_i = 1'b0;
      push(5'd7, 64'h77);
      @(negedge clk_i);
      check("stv_drain_v", {63'd0, rd_w_v_o}, 64'd1);
      check("stv_drain_stall", {63'd0, long_stall_o}, 64'd1);
      next_cycle();
      @(negedge clk_i);
      check("stv_after_stall", {63'd0, long_stall_o}, 64'd0);
      check("stv_after_ready", {63'd0, long_ready_o}, 64'd1);
      next_cycle();

      // ---------------- mid-run reset ----------------
      pipe_w_v_i = 1'b1; pipe_addr_i = 5'd2;  pipe_data_i = 64'h22;
      long_v_i   = 1'b1; long_addr_i = 5'd9;  long_data_i = 64'h99;
      cfg_w_v_i  = 1'b1; cfg_addr_i  = 5'd10; cfg_data_i  = 64'h10;
      push(5'd2, 64'h22);
      @(negedge clk_i);
      check("mrst_ack0", {63'd0, cfg_ack_o}, 64'd0);
      next_cycle();
      pipe_w_v_i = 1'b0;
      long_v_i   = 1'b0;
      reset_i    = 1'b1;
      @(negedge clk_i);
      check("mrst_ack", {63'd0, cfg_ack_o}, 64'd0);
      check("mrst_wv", {63'd0, rd_w_v_o}, 64'd0);
      next_cycle();
      reset_i   = 1'b0;
      cfg_w_v_i = 1'b0;
`ifdef BP_BE_RF_CLEAR_ON_RESET_EN
      run_clear();
      @(negedge clk_i);
      check("mrst_done", {63'd0, init_done_o}, 64'd1);
      next_cycle();
`else
      @(negedge clk_i);
      check("mrst_wv_after", {63'd0, rd_w_v_o}, 64'd0);
      check("mrst_ready", {63'd0, long_ready_o}, 64'd1);
      check("mrst_done", {63'd0, init_done_o}, 64'd1);
      next_cycle();
`endif
      repeat (4) next_cycle();
      check("sb_empty", 64'(sb_q.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
